// File: rtl/serial_word_feeder_if.sv
// Parallel-word handshake between a producer and the serial word feeder.
interface serial_word_feeder_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_dir;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_dir, output in_valid, input in_ready);
    modport slave  (input in_data, input in_dir, input in_valid, output in_ready);
endinterface

// File: rtl/serial_word_feeder.sv
// Serializes a handshaked parallel word into a bidirectional shift register,
// with optional stall, a done pulse and a programmable idle gap between words.
module serial_word_feeder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_word_feeder_if.slave   in_if,
    input  logic                  hold,
    output logic                  sr_d,
    output logic                  sr_en,
    output logic                  sr_dir,
    output logic                  busy,
    output logic                  word_done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned GW = (GAP < 2) ? 1 : $clog2(GAP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE,
        ST_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             sr_d_q, sr_d_d;
    logic             sr_dir_q, sr_dir_d;
    logic             word_done_q, word_done_d;
    logic             busy_q, busy_d;

    // State and datapath registers; reset discards any word in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            sr_d_q      <= 1'b0;
            sr_dir_q    <= 1'b0;
            word_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            sr_d_q      <= sr_d_d;
            sr_dir_q    <= sr_dir_d;
            word_done_q <= word_done_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; the holding register shifts so the next bit sits next to the edge
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        sr_d_d      = sr_d_q;
        sr_dir_d    = sr_dir_q;
        word_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_if.in_valid) begin
                    data_d   = in_if.in_data;
                    sr_dir_d = in_if.in_dir;
                    cnt_d    = '0;
                    sr_d_d   = in_if.in_dir ? in_if.in_data[0] : in_if.in_data[WIDTH-1];
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!hold) begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d     = ST_DONE;
                        word_done_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        data_d = sr_dir_q ? (data_q >> 1) : (data_q << 1);
                        sr_d_d = sr_dir_q ? data_q[1] : data_q[WIDTH-2];
                    end
                end
            end
            ST_DONE: begin
                gap_d   = '0;
                state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Ready and enable must react within the cycle to reset and stall
    assign in_if.in_ready = (state_q == ST_IDLE) & ~rst;
    assign sr_en          = (state_q == ST_SHIFT) & ~hold;
    assign sr_d           = sr_d_q;
    assign sr_dir         = sr_dir_q;
    assign word_done      = word_done_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder with a phase-index reference model.
module tb_serial_word_feeder;

    localparam int W  = 4;
    localparam int G0 = 1;

    logic clk = 1'b0;
    logic rst;
    logic hold;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic sr_d0, sr_en0, sr_dir0, busy0, done0;
    logic sr_d1, sr_en1, sr_dir1, busy1, done1;

    serial_word_feeder_if #(.WIDTH(W)) i0 ();
    serial_word_feeder_if #(.WIDTH(W)) i1 ();

    serial_word_feeder #(.WIDTH(W), .GAP(G0)) dut0 (
        .clk(clk), .rst(rst), .in_if(i0), .hold(hold),
        .sr_d(sr_d0), .sr_en(sr_en0), .sr_dir(sr_dir0), .busy(busy0), .word_done(done0)
    );

    serial_word_feeder #(.WIDTH(W), .GAP(0)) dut1 (
        .clk(clk), .rst(rst), .in_if(i1), .hold(1'b0),
        .sr_d(sr_d1), .sr_en(sr_en1), .sr_dir(sr_dir1), .busy(busy1), .word_done(done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: m_ph = -1 idle, 0..W-1 presenting that bit, W done, above W gap
    int         m_ph   = -1;
    logic [W-1:0] m_word = '0;
    logic       m_dir  = 1'b0;
    logic       m_d    = 1'b0;

    function automatic logic m_bit(input int k);
        return m_dir ? m_word[k] : m_word[W-1-k];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph  <= -1;
            m_dir <= 1'b0;
            m_d   <= 1'b0;
        end else if (m_ph < 0) begin
            if (i0.in_valid) begin
                m_word <= i0.in_data;
                m_dir  <= i0.in_dir;
                m_ph   <= 0;
                m_d    <= i0.in_dir ? i0.in_data[0] : i0.in_data[W-1];
            end
        end else if (m_ph < W) begin
            if (!hold) begin
                m_ph <= m_ph + 1;
                if (m_ph + 1 < W) m_d <= m_bit(m_ph + 1);
            end
        end else if (m_ph >= W + G0) begin
            m_ph <= -1;
        end else begin
            m_ph <= m_ph + 1;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("in_ready",  32'(i0.in_ready), 32'((m_ph < 0) && !rst));
        chk("busy",      32'(busy0),       32'(m_ph >= 0));
        chk("sr_en",     32'(sr_en0),      32'((m_ph >= 0) && (m_ph < W) && !hold));
        chk("sr_d",      32'(sr_d0),       32'(m_d));
        chk("sr_dir",    32'(sr_dir0),     32'(m_dir));
        chk("word_done", 32'(done0),       32'(m_ph == W));
    end

    // Downstream shift registers fed by each feeder
    logic [W-1:0] down0, down1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            down0 <= '0;
            down1 <= '0;
        end else begin
            if (sr_en0) down0 <= sr_dir0 ? {sr_d0, down0[W-1:1]} : {down0[W-2:0], sr_d0};
            if (sr_en1) down1 <= sr_dir1 ? {sr_d1, down1[W-1:1]} : {down1[W-2:0], sr_d1};
        end
    end

    // Observed serial bits and done pulses of the GAP=1 feeder
    logic seq[$];
    int   done_cnt = 0;
    always @(negedge clk) begin
        if (sr_en0) seq.push_back(sr_d0);
        if (done0) done_cnt <= done_cnt + 1;
    end

    function automatic logic [31:0] seq_val();
        logic [31:0] v = '0;
        foreach (seq[i]) v = {v[30:0], seq[i]};
        return v;
    endfunction

    task automatic wait_ready(input int sel, output int c);
        c = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((sel == 1) ? i1.in_ready : i0.in_ready) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: dut%0d never raised in_ready", sel);
        end
    endtask

    task automatic wait_done(input int sel, output int c);
        c = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if ((sel == 1) ? done1 : done0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: dut%0d never pulsed word_done", sel);
        end
    endtask

    task automatic send(input logic [W-1:0] w, input logic d, output int acc);
        @(posedge clk);
        #1;
        i0.in_data  = w;
        i0.in_dir   = d;
        i0.in_valid = 1'b1;
        wait_ready(0, acc);
        @(posedge clk);
        #1;
        i0.in_valid = 1'b0;
        i0.in_data  = ~w;
        i0.in_dir   = ~d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a2, d, dbefore;

        // Reset with a pending word: nothing may be accepted
        rst = 1'b1;
        hold = 1'b0;
        i0.in_valid = 1'b1; i0.in_data = 4'hF; i0.in_dir = 1'b0;
        i1.in_valid = 1'b0; i1.in_data = 4'h0; i1.in_dir = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(i0.in_ready), 32'd0);
        chk("rst_en",    32'(sr_en0),      32'd0);
        chk("rst_d",     32'(sr_d0),       32'd0);
        chk("rst_busy",  32'(busy0),       32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        i0.in_valid = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(i0.in_ready), 32'd1);
        chk("rel_busy",  32'(busy0),       32'd0);

        // MSB-first word
        seq.delete();
        send(4'b1011, 1'b0, a);
        wait_done(0, d);
        chk("s2_latency", 32'(d - a), 32'd5);
        chk("s2_bits",    seq_val(), 32'b1011);
        chk("s2_pulses",  32'(seq.size()), 32'd4);
        chk("s2_down",    32'(down0), 32'b1011);
        @(negedge clk);
        chk("s2_gap_ready", 32'(i0.in_ready), 32'd0);
        @(negedge clk);
        chk("s2_idle_ready", 32'(i0.in_ready), 32'd1);

        // LSB-first word
        seq.delete();
        send(4'b1011, 1'b1, a);
        wait_done(0, d);
        chk("s3_bits", seq_val(), 32'b1101);
        chk("s3_down", 32'(down0), 32'b1011);
        chk("s3_dir",  32'(sr_dir0), 32'd1);

        // Stall for two cycles after the second bit
        seq.delete();
        send(4'b0110, 1'b0, a);
        @(posedge clk);
        @(posedge clk);
        #1;
        hold = 1'b1;
        @(negedge clk);
        chk("s4_stall_en", 32'(sr_en0), 32'd0);
        chk("s4_stall_d",  32'(sr_d0),  32'd1);
        @(negedge clk);
        chk("s4_stall_en2", 32'(sr_en0), 32'd0);
        chk("s4_stall_d2",  32'(sr_d0),  32'd1);
        @(posedge clk);
        #1;
        hold = 1'b0;
        wait_done(0, d);
        chk("s4_latency", 32'(d - a), 32'd7);
        chk("s4_bits",    seq_val(), 32'b0110);
        chk("s4_pulses",  32'(seq.size()), 32'd4);
        chk("s4_down",    32'(down0), 32'b0110);

        // Back-to-back words, GAP=1
        seq.delete();
        @(posedge clk);
        #1;
        i0.in_valid = 1'b1; i0.in_data = 4'hA; i0.in_dir = 1'b0;
        wait_ready(0, a);
        @(posedge clk);
        #1;
        i0.in_data = 4'h5;
        wait_ready(0, a2);
        @(posedge clk);
        #1;
        i0.in_valid = 1'b0;
        wait_done(0, d);
        chk("s5_spacing_g1", 32'(a2 - a), 32'd7);
        chk("s5_bits",       seq_val(), 32'hA5);
        chk("s5_down",       32'(down0), 32'h5);

        // Back-to-back words, GAP=0
        @(posedge clk);
        #1;
        i1.in_valid = 1'b1; i1.in_data = 4'hA; i1.in_dir = 1'b0;
        wait_ready(1, a);
        @(posedge clk);
        #1;
        i1.in_data = 4'h5;
        wait_ready(1, a2);
        @(posedge clk);
        #1;
        i1.in_valid = 1'b0;
        wait_done(1, d);
        chk("s5_spacing_g0", 32'(a2 - a), 32'd6);
        chk("s5_down_g0",    32'(down1), 32'h5);

        // Reset in the middle of a word
        dbefore = done_cnt;
        send(4'b1100, 1'b0, a);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("s6_en_drop",   32'(sr_en0), 32'd0);
        chk("s6_busy_drop", 32'(busy0),  32'd0);
        chk("s6_d_drop",    32'(sr_d0),  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("s6_rel_ready", 32'(i0.in_ready), 32'd1);
        #1;
        chk("s6_no_done", 32'(done_cnt), 32'(dbefore));
        seq.delete();
        send(4'b0011, 1'b0, a);
        wait_done(0, d);
        chk("s6_bits", seq_val(), 32'b0011);
        chk("s6_down", 32'(down0), 32'b0011);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Upstream stage of the bidirectional shift register. It accepts a parallel word over a valid/ready handshake and emits it one bit at a time.
- Drives the shift register's serial-data, enable and direction inputs.
- After WIDTH enabled shifts, the downstream register holds the word in its original bit order.
- Adds a done pulse, a stall input and a programmable idle gap between words.

Parameters:
- WIDTH, 4, word width in bits; must equal the downstream shift register width; legal range 2..32.
- GAP, 1, idle cycles inserted after each word before the next is accepted; 0 is legal.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  WIDTH  parallel word to serialize.
- in_dir  input  1  shift direction, captured with the word.
- in_valid  input  1  in_data/in_dir valid.
- in_ready  output  1  feeder can accept a word.
- hold  input  1  stall shifting while high.
- sr_d  output  1  serial bit to the shift register's d input.
- sr_en  output  1  shift enable to the shift register.
- sr_dir  output  1  direction to the shift register.
- busy  output  1  high in any state other than IDLE.
- word_done  output  1  one-cycle pulse after the last bit of a word.

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: state=IDLE, bit counter=0, gap counter=0, sr_d=0, sr_en=0, sr_dir=0, word_done=0, busy=0.
- in_ready = (state==IDLE) & ~rst, so in_ready is 0 while rst is high.
- States: IDLE, SHIFT, DONE, GAP.
- IDLE:
  - in_ready=1, sr_en=0.
  - Accept on a rising edge with in_valid & in_ready: latch in_data into the holding register, latch in_dir into sr_dir, clear the bit counter, go to SHIFT.
  - hold is ignored in IDLE.
- SHIFT:
  - sr_en = ~hold.
  - sr_d = current bit of the holding register.
  - Bit order for in_dir=0: bit WIDTH-1 first, down to bit 0.
  - Bit order for in_dir=1: bit 0 first, up to bit WIDTH-1.
  - On each edge with hold=0, advance to the next bit and increment the counter.
  - On the edge that consumes bit index WIDTH-1 (counter==WIDTH-1, hold=0), go to DONE.
  - With hold=1: sr_en=0, sr_d and the counter do not change.
- DONE:
  - Lasts exactly 1 cycle: word_done=1, sr_en=0.
  - Next state is GAP if GAP>0, else IDLE.
- GAP:
  - Lasts GAP cycles: sr_en=0, in_ready=0.
  - The gap counter is unaffected by hold.
  - Next state is IDLE.
- Latency and throughput:
  - First bit is presented in the cycle immediately after the accepting edge; downstream samples it on the next edge.
  - With no stalls, accepting edges are spaced WIDTH+GAP+2 cycles apart (IDLE 1 + SHIFT WIDTH + DONE 1 + GAP).
- Stability:
  - sr_dir stays constant from acceptance until the next acceptance, including across IDLE.
  - sr_d holds its last value while sr_en=0 outside SHIFT.
- Handshake: in_data/in_dir are sampled only on the accepting edge. Changes at any other time have no effect.
- Simultaneous events: in_valid during SHIFT, DONE or GAP is not accepted and stays pending. No data is lost, because the producer must hold it until in_ready.
- Reset mid-operation:
  - All registers and outputs return immediately (asynchronously) to reset values.
  - The word in flight is discarded and no word_done is issued.
  - The first cycle after release is IDLE with in_ready=1.
- Counter width is clog2(WIDTH); it never wraps past WIDTH-1.

Test Plan (WIDTH=4, GAP=1 unless stated):
1. Reset: rst=1 with in_valid=1 -> in_ready=0, sr_en=0, sr_d=0, busy=0, nothing accepted. Release rst -> in_ready=1 in the first cycle.
2. MSB-first: in_data=4'b1011, in_dir=0 -> sr_d=1,0,1,1 on 4 consecutive cycles with sr_en=1, sr_dir=0. word_done pulses 1 cycle next. in_ready returns after 1 GAP cycle. Downstream register reads 4'b1011.
3. LSB-first: in_data=4'b1011, in_dir=1 -> sr_d=1,1,0,1 with sr_dir=1 throughout. Downstream register reads 4'b1011.
4. Stall: in_data=4'b0110, in_dir=0, hold=1 for 2 cycles after bit 1 -> sr_en=0 and sr_d=1 held for those 2 cycles, then bits resume. word_done arrives 2 cycles later than in scenario 2, with exactly 4 sr_en pulses.
5. Back-to-back: in_valid held high with words 4'hA then 4'h5 -> accepting edges exactly 7 cycles apart. With GAP=0 they are 6 apart. The second word's bits are not corrupted.
6. Reset mid-word: assert rst after 2 bits of 4'b1100 -> sr_en drops immediately and no word_done is issued. After release, 4'b0011 serializes cleanly as 0,0,1,1.
